// File: rtl/axi8_pkg.sv
// Shared types and constants for the 8-bit AXI4-Lite master and its watchdog.
package axi8_pkg;

    // Master FSM states; the values are visible on the debug state port
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5,
        ST_RSP  = 3'd6
    } state_e;

    // AXI response codes used by the master
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Default widths and watchdog limit
    localparam int DEF_ADDR_WIDTH = 1;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_TIMEOUT    = 255;
    localparam int DEF_TO_W       = 8;

    // True for the states that wait on a slave handshake (watched by the watchdog)
    function automatic logic is_phase(state_e s);
        return (s == ST_AW) || (s == ST_W) || (s == ST_B) || (s == ST_AR) || (s == ST_R);
    endfunction

endpackage

// File: rtl/axi8_wdog.sv
// Per-phase watchdog: counts cycles while enabled and flags the last allowed cycle.
// `expired` is high for exactly the cycle where count == TIMEOUT-1; TIMEOUT=0 disables it.
module axi8_wdog
    import axi8_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TO_W    = DEF_TO_W
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count;

    // Cycle counter: cleared on reset and on every state change, advanced while waiting on a phase
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TO_W'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/axi8_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AW/W/B or AR/R sequence out,
// one response back. A per-phase watchdog turns a hung slave into a SLVERR/timeout response.
//
// Handshake rule for every channel here (cmd, rsp, AW, W, B, AR, R): a transfer happens on the
// rising clk edge where VALID and READY are both high; once VALID is raised it stays high with a
// stable payload until that transfer, except that a watchdog abort may withdraw AW/W/AR VALID.
module axi8_lite_master
    import axi8_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int TO_W       = DEF_TO_W
) (
    input  logic                    clk,
    input  logic                    reset,
    // command port
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    // response port
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_tmo,
    output logic                    busy,
    // AXI write address / data / response
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,
    output logic                    BREADY,
    input  logic                    BVALID,
    input  logic [1:0]              BRESP,
    // AXI read address / data
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    output logic                    RREADY,
    input  logic                    RVALID,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP,
    // debug
    output state_e                  dbg_state
);

    localparam int STRB_W = DATA_WIDTH / 8;

    state_e                state;
    state_e                state_next;
    logic                  accept;
    logic                  hs;
    logic                  expired;
    logic                  tmo_abort;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;

    // cmd_ready is the only combinational output; held low while reset is asserted
    assign cmd_ready = (state == ST_IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign dbg_state = state;

    // Payload registers shared by both address channels
    assign AWADDR = addr_q;
    assign ARADDR = addr_q;
    assign WDATA  = wdata_q;
    assign WSTRB  = wstrb_q;

    // Handshake completion for the phase the FSM is currently waiting on
    always_comb begin
        hs = 1'b0;
        unique case (state)
            ST_AW:   hs = AWREADY;
            ST_W:    hs = WREADY;
            ST_B:    hs = BVALID;
            ST_AR:   hs = ARREADY;
            ST_R:    hs = RVALID;
            default: hs = 1'b0;
        endcase
    end

    // A handshake on the threshold cycle wins over the abort
    assign tmo_abort = expired && !hs;

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (accept) state_next = cmd_write ? ST_AW : ST_AR;
            ST_AW:   if (hs) state_next = ST_W;   else if (tmo_abort) state_next = ST_RSP;
            ST_W:    if (hs) state_next = ST_B;   else if (tmo_abort) state_next = ST_RSP;
            ST_B:    if (hs) state_next = ST_RSP; else if (tmo_abort) state_next = ST_RSP;
            ST_AR:   if (hs) state_next = ST_R;   else if (tmo_abort) state_next = ST_RSP;
            ST_R:    if (hs) state_next = ST_RSP; else if (tmo_abort) state_next = ST_RSP;
            ST_RSP:  if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Watchdog restarts on every state change and runs only while waiting on the slave
    axi8_wdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_next != state),
        .enable  (is_phase(state)),
        .expired (expired)
    );

    // Registered outputs decoded from the next state, plus command and response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            AWVALID   <= 1'b0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
            rsp_tmo   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            AWVALID   <= (state_next == ST_AW);
            WVALID    <= (state_next == ST_W);
            BREADY    <= (state_next == ST_B);
            ARVALID   <= (state_next == ST_AR);
            RREADY    <= (state_next == ST_R);
            rsp_valid <= (state_next == ST_RSP);
            busy      <= (state_next != ST_IDLE);

            if (accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
            end

            if (state == ST_B && BVALID) begin
                rsp_rdata <= '0;
                rsp_resp  <= BRESP;
                rsp_tmo   <= 1'b0;
            end else if (state == ST_R && RVALID) begin
                rsp_rdata <= RDATA;
                rsp_resp  <= RRESP;
                rsp_tmo   <= 1'b0;
            end else if (tmo_abort) begin
                rsp_rdata <= '0;
                rsp_resp  <= RESP_SLVERR;
                rsp_tmo   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi8_lite_master.sv
// Directed bench for axi8_lite_master against a small zero-wait slave model.
// Slave map: addr0 is an 8-bit register (written when WSTRB[0]=1), addr1 reads back ~reg0.
// Latency is the number of clock edges from the accept edge to the first edge at which
// rsp_valid is presented (sampled on the falling edge just before it).
module tb_axi8_lite_master;
    import axi8_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [0:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [0:0] cmd_wstrb;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_resp;
    logic       rsp_tmo, busy;
    logic [0:0] AWADDR, ARADDR;
    logic       AWVALID, AWREADY, WVALID, WREADY, BREADY, BVALID, ARVALID, ARREADY, RREADY, RVALID;
    logic [7:0] WDATA, RDATA;
    logic [0:0] WSTRB;
    logic [1:0] BRESP, RRESP;
    state_e     dbg_state;

    int compared   = 0;
    int mismatched = 0;

    // Slave model state
    logic       stall_aw;
    logic [7:0] s_mem;
    logic [0:0] s_awaddr;
    logic       s_bvalid, s_rvalid;
    logic [7:0] s_rdata;

    // Shared result holders for the stimulus tasks
    int         lat;
    logic [7:0] rd;
    logic [1:0] rr;
    logic       tm;

    // Clock and DUT
    always #5 clk = ~clk;

    axi8_lite_master #(
        .ADDR_WIDTH (1),
        .DATA_WIDTH (8),
        .TIMEOUT    (4),
        .TO_W       (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .rsp_tmo   (rsp_tmo),
        .busy      (busy),
        .AWADDR    (AWADDR),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BREADY    (BREADY),
        .BVALID    (BVALID),
        .BRESP     (BRESP),
        .ARADDR    (ARADDR),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RREADY    (RREADY),
        .RVALID    (RVALID),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .dbg_state (dbg_state)
    );

    // Zero-wait slave: address/data readies always high (AW can be stalled), B/R one cycle later
    assign AWREADY = !stall_aw;
    assign WREADY  = 1'b1;
    assign ARREADY = 1'b1;
    assign BVALID  = s_bvalid;
    assign BRESP   = RESP_OKAY;
    assign RVALID  = s_rvalid;
    assign RDATA   = s_rdata;
    assign RRESP   = RESP_OKAY;

    // Slave register file and response channels, reset together with the master
    always_ff @(posedge clk) begin
        if (reset) begin
            s_mem    <= 8'h00;
            s_awaddr <= 1'b0;
            s_bvalid <= 1'b0;
            s_rvalid <= 1'b0;
            s_rdata  <= 8'h00;
        end else begin
            if (AWVALID && AWREADY) s_awaddr <= AWADDR;
            if (WVALID && WREADY) begin
                if (s_awaddr == 1'b0 && WSTRB[0]) s_mem <= WDATA;
                s_bvalid <= 1'b1;
            end else if (BREADY && s_bvalid) begin
                s_bvalid <= 1'b0;
            end
            if (ARVALID && ARREADY) begin
                s_rvalid <= 1'b1;
                s_rdata  <= (ARADDR == 1'b1) ? ~s_mem : s_mem;
            end else if (RREADY && s_rvalid) begin
                s_rvalid <= 1'b0;
            end
        end
    end

    // Present a command and return just after its accept edge
    task automatic start_cmd(input logic wr, input logic a, input logic [7:0] d, input logic s);
        int budget;
        @(negedge clk);
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        cmd_valid = 1'b1;
        budget = 0;
        while (!cmd_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        compared++;
        if (cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid and capture the response without consuming it
    task automatic wait_rsp();
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 40);
        compared++;
        if (rsp_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
        end
        rd = rsp_rdata;
        rr = rsp_resp;
        tm = rsp_tmo;
    endtask

    // Consume the pending response; returns on the falling edge after the handshake
    task automatic consume_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic run_cmd(input logic wr, input logic a, input logic [7:0] d, input logic s);
        start_cmd(wr, a, d, s);
        wait_rsp();
        consume_rsp();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, busy, cmd_ready} !== 8'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: aw/w/b/ar/r/rsp/busy/cmd_ready=%b required 00000000",
                     {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, busy, cmd_ready});
        end
        compared++;
        if ({rsp_rdata, rsp_resp, rsp_tmo} !== 11'b0) begin
            mismatched++;
            $display("FAIL reset_rsp: rdata=%h resp=%b tmo=%b required 00/00/0", rsp_rdata, rsp_resp, rsp_tmo);
        end
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if (cmd_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            mismatched++;
            $display("FAIL reset_release: cmd_ready=%b state=%0d required 1/IDLE", cmd_ready, dbg_state);
        end
    endtask

    task automatic test_write_read();
        run_cmd(1'b1, 1'b0, 8'hA5, 1'b1);
        compared++;
        if (lat !== 4) begin
            mismatched++;
            $display("FAIL write_latency: got %0d required 4", lat);
        end
        compared++;
        if ({rd, rr, tm} !== {8'h00, RESP_OKAY, 1'b0}) begin
            mismatched++;
            $display("FAIL write_rsp: rdata=%h resp=%b tmo=%b required 00/00/0", rd, rr, tm);
        end
        run_cmd(1'b0, 1'b1, 8'h00, 1'b0);
        compared++;
        if ({rd, rr, tm} !== {8'h5A, RESP_OKAY, 1'b0}) begin
            mismatched++;
            $display("FAIL read_addr1: rdata=%h resp=%b tmo=%b required 5a/00/0", rd, rr, tm);
        end
    endtask

    task automatic test_read_latency();
        run_cmd(1'b0, 1'b0, 8'h00, 1'b0);
        compared++;
        if (rd !== 8'hA5) begin
            mismatched++;
            $display("FAIL read_addr0: rdata=%h required a5", rd);
        end
        compared++;
        if (lat !== 3) begin
            mismatched++;
            $display("FAIL read_latency: got %0d required 3", lat);
        end
    endtask

    task automatic test_wstrb_zero();
        run_cmd(1'b1, 1'b0, 8'hFF, 1'b0);
        compared++;
        if (lat !== 4 || rr !== RESP_OKAY) begin
            mismatched++;
            $display("FAIL wstrb0_write: latency=%0d resp=%b required 4/00", lat, rr);
        end
        run_cmd(1'b0, 1'b1, 8'h00, 1'b0);
        compared++;
        if (rd !== 8'h5A) begin
            mismatched++;
            $display("FAIL wstrb0_read: rdata=%h required 5a", rd);
        end
    endtask

    task automatic test_rsp_backpressure();
        start_cmd(1'b0, 1'b1, 8'h00, 1'b0);
        wait_rsp();
        // next command waits behind the unconsumed response
        cmd_write = 1'b1;
        cmd_addr  = 1'b0;
        cmd_wdata = 8'h3C;
        cmd_wstrb = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            compared++;
            if ({cmd_ready, rsp_valid, busy, rsp_rdata, rsp_resp, rsp_tmo} !== {1'b0, 1'b1, 1'b1, 8'h5A, 2'b00, 1'b0}) begin
                mismatched++;
                $display("FAIL hold_rsp[%0d]: cmd_ready=%b rsp_valid=%b busy=%b rdata=%h resp=%b tmo=%b required 0/1/1/5a/00/0",
                         i, cmd_ready, rsp_valid, busy, rsp_rdata, rsp_resp, rsp_tmo);
            end
            @(negedge clk);
        end
        consume_rsp();
        compared++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
            mismatched++;
            $display("FAIL after_rsp: rsp_valid/cmd_ready/busy=%b required 010", {rsp_valid, cmd_ready, busy});
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        compared++;
        if ({busy, AWVALID, cmd_ready, AWADDR, WDATA} !== {3'b110, 1'b0, 8'h3C}) begin
            mismatched++;
            $display("FAIL next_accept: busy/awvalid/cmd_ready=%b awaddr=%b wdata=%h required 110/0/3c",
                     {busy, AWVALID, cmd_ready}, AWADDR, WDATA);
        end
        wait_rsp();
        consume_rsp();
        run_cmd(1'b0, 1'b1, 8'h00, 1'b0);
        compared++;
        if (rd !== 8'hC3) begin
            mismatched++;
            $display("FAIL queued_write_read: rdata=%h required c3", rd);
        end
    endtask

    task automatic test_timeout();
        int aw_cycles;
        int budget;
        stall_aw = 1'b1;
        start_cmd(1'b1, 1'b0, 8'h11, 1'b1);
        aw_cycles = 0;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
            if (AWVALID) aw_cycles++;
        end while (!rsp_valid && budget < 20);
        compared++;
        if (aw_cycles !== 4) begin
            mismatched++;
            $display("FAIL tmo_aw_cycles: got %0d required 4", aw_cycles);
        end
        compared++;
        if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, busy} !== 7'b0000011) begin
            mismatched++;
            $display("FAIL tmo_ctrl: aw/w/b/ar/r/rsp/busy=%b required 0000011",
                     {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, busy});
        end
        compared++;
        if ({rsp_rdata, rsp_resp, rsp_tmo} !== {8'h00, RESP_SLVERR, 1'b1}) begin
            mismatched++;
            $display("FAIL tmo_rsp: rdata=%h resp=%b tmo=%b required 00/10/1", rsp_rdata, rsp_resp, rsp_tmo);
        end
        stall_aw = 1'b0;
        consume_rsp();
        compared++;
        if ({busy, cmd_ready, rsp_valid} !== 3'b010) begin
            mismatched++;
            $display("FAIL tmo_release: busy/cmd_ready/rsp_valid=%b required 010", {busy, cmd_ready, rsp_valid});
        end
        // aborted write must not have reached the slave
        run_cmd(1'b0, 1'b0, 8'h00, 1'b0);
        compared++;
        if (rd !== 8'h3C) begin
            mismatched++;
            $display("FAIL tmo_no_write: rdata=%h required 3c", rd);
        end
    endtask

    task automatic test_timeout_edge();
        // AWREADY arrives on the 4th AW cycle, exactly the threshold cycle: must succeed
        stall_aw = 1'b1;
        start_cmd(1'b1, 1'b0, 8'h77, 1'b1);
        repeat (4) @(negedge clk);
        stall_aw = 1'b0;
        wait_rsp();
        consume_rsp();
        compared++;
        if ({rr, tm} !== {RESP_OKAY, 1'b0} || (lat + 4) !== 7) begin
            mismatched++;
            $display("FAIL edge_write: resp=%b tmo=%b latency=%0d required 00/0/7", rr, tm, lat + 4);
        end
        run_cmd(1'b0, 1'b0, 8'h00, 1'b0);
        compared++;
        if (rd !== 8'h77) begin
            mismatched++;
            $display("FAIL edge_read: rdata=%h required 77", rd);
        end
    endtask

    task automatic test_reset_mid();
        int budget;
        start_cmd(1'b1, 1'b0, 8'h99, 1'b1);
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (dbg_state !== ST_B && budget < 10);
        compared++;
        if (dbg_state !== ST_B || BREADY !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_reach_b: state=%0d bready=%b required B/1", dbg_state, BREADY);
        end
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, busy, cmd_ready} !== 8'b0) begin
            mismatched++;
            $display("FAIL mid_reset: aw/w/b/ar/r/rsp/busy/cmd_ready=%b required 00000000",
                     {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, busy, cmd_ready});
        end
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin
            mismatched++;
            $display("FAIL mid_release: cmd_ready/rsp_valid/busy=%b required 100", {cmd_ready, rsp_valid, busy});
        end
        // slave register cleared by the shared reset; the discarded response never shows up
        run_cmd(1'b0, 1'b0, 8'h00, 1'b0);
        compared++;
        if ({rd, rr, tm} !== {8'h00, RESP_OKAY, 1'b0}) begin
            mismatched++;
            $display("FAIL mid_post_read: rdata=%h resp=%b tmo=%b required 00/00/0", rd, rr, tm);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 1'b0;
        cmd_wdata = 8'h00;
        cmd_wstrb = 1'b0;
        rsp_ready = 1'b0;
        stall_aw  = 1'b0;

        test_reset();
        test_write_read();
        test_read_latency();
        test_wstrb_zero();
        test_rsp_backpressure();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard stop if anything above stalls
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "global timeout");
    end

endmodule
